// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the result readout block.
package conv_pkg;

    localparam int unsigned DEF_ADDR_W         = 12;
    localparam int unsigned DEF_DATA_W         = 16;
    localparam int unsigned DEF_LAUNCH_TIMEOUT = 255;
    localparam int unsigned STATE_W            = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_READ   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_HOLD   = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

endpackage

// File: rtl/result_readout_if.sv
// Output-SRAM read port plus host result stream, bundled for the readout block.
interface result_readout_if
    import conv_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic              out_sram_re;
    logic [ADDR_W-1:0] out_sram_addr;
    logic [DATA_W-1:0] out_sram_rdata;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              rd_ready;

    // Readout side: drives SRAM reads and the host stream.
    modport master (
        output out_sram_re,
        output out_sram_addr,
        input  out_sram_rdata,
        output rd_valid,
        output rd_data,
        output rd_last,
        input  rd_ready
    );

    // SRAM model / host side.
    modport slave (
        input  out_sram_re,
        input  out_sram_addr,
        output out_sram_rdata,
        input  rd_valid,
        input  rd_data,
        input  rd_last,
        output rd_ready
    );

endinterface

// File: rtl/result_readout.sv
// Launches a controller run, counts snooped output writes, then streams the
// written words back from the output SRAM to the host.
module result_readout
    import conv_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned LAUNCH_TIMEOUT = DEF_LAUNCH_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              host_start,
    output logic              host_busy,
    output logic              dut_run,
    input  logic              dut_busy,
    input  logic              snoop_we,
    result_readout_if.master  rd_if,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              err
);

    localparam int unsigned TO_W = $clog2(LAUNCH_TIMEOUT + 1);
    localparam int unsigned WC_W = ADDR_W + 1;
    localparam logic [WC_W-1:0] WC_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WC_W-1:0]   wc_q, wc_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              last_q, last_d;
    logic              err_q, err_d;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: timeout, address, word count, holding word, flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt_q <= '0;
            addr_q   <= '0;
            wc_q     <= '0;
            hold_q   <= '0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            addr_q   <= addr_d;
            wc_q     <= wc_d;
            hold_q   <= hold_d;
            last_q   <= last_d;
            err_q    <= err_d;
        end
    end

    // Next-state and datapath update; the busy-fall decision sees a coincident write.
    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        addr_d   = addr_q;
        wc_d     = wc_q;
        hold_d   = hold_q;
        last_d   = last_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (host_start) begin
                    wc_d     = '0;
                    err_d    = 1'b0;
                    to_cnt_d = '0;
                    state_d  = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (dut_busy) begin
                    state_d = ST_RUN;
                end else if (to_cnt_q == TO_W'(LAUNCH_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_RUN: begin
                if (snoop_we && (wc_q != WC_MAX)) begin
                    wc_d = wc_q + WC_W'(1);
                end
                if (!dut_busy) begin
                    addr_d  = '0;
                    state_d = (wc_d == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                hold_d  = rd_if.out_sram_rdata;
                last_d  = ({1'b0, addr_q} == (wc_q - WC_W'(1)));
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (rd_if.rd_ready) begin
                    last_d = 1'b0;
                    if (last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the state register or taken straight from registers.
    assign host_busy           = (state_q != ST_IDLE);
    assign dut_run             = (state_q == ST_LAUNCH);
    assign rd_if.out_sram_re   = (state_q == ST_READ);
    assign rd_if.out_sram_addr = addr_q;
    assign rd_if.rd_valid      = (state_q == ST_HOLD);
    assign rd_if.rd_data       = hold_q;
    assign rd_if.rd_last       = last_q;
    assign word_count          = wc_q;
    assign done                = (state_q == ST_DONE);
    assign err                 = err_q;

endmodule

// File: tb/tb_result_readout.sv
// Self-checking bench for result_readout: controller/SRAM/host models plus a
// queue-based scoreboard of the words each run must return.
module tb_result_readout;
    import conv_pkg::*;

    localparam int unsigned AW    = DEF_ADDR_W;
    localparam int unsigned DW    = DEF_DATA_W;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          host_start = 1'b0;
    logic          dut_busy = 1'b0;
    logic          snoop_we = 1'b0;
    logic          host_busy, dut_run, done, err;
    logic [AW:0]   word_count;

    result_readout_if #(.ADDR_W(AW), .DATA_W(DW)) rif ();

    result_readout dut (
        .clock      (clk),
        .reset      (rst_n),
        .host_start (host_start),
        .host_busy  (host_busy),
        .dut_run    (dut_run),
        .dut_busy   (dut_busy),
        .snoop_we   (snoop_we),
        .rd_if      (rif.master),
        .word_count (word_count),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem   [0:DEPTH-1];
    logic [DW-1:0] wdata [0:8191];
    logic [DW-1:0] exp_q [$];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, beats = 0, beat_base = 0, re_cnt = 0, run_cyc = 0;
    int valid_cyc = 0, done_cnt = 0, done_cyc = 0, last_acc_cyc = 0;
    int ready_mode = 0;

    // Output SRAM model: one-cycle read latency.
    always @(posedge clk) begin
        if (rif.out_sram_re) rif.out_sram_rdata <= mem[rif.out_sram_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
        end
    endfunction

    function automatic void chk_zero(string nm);
        chk({nm, "_host_busy"}, 32'(host_busy), 0);
        chk({nm, "_dut_run"}, 32'(dut_run), 0);
        chk({nm, "_sram_re"}, 32'(rif.out_sram_re), 0);
        chk({nm, "_sram_addr"}, 32'(rif.out_sram_addr), 0);
        chk({nm, "_rd_valid"}, 32'(rif.rd_valid), 0);
        chk({nm, "_rd_data"}, 32'(rif.rd_data), 0);
        chk({nm, "_rd_last"}, 32'(rif.rd_last), 0);
        chk({nm, "_word_count"}, 32'(word_count), 0);
        chk({nm, "_done"}, 32'(done), 0);
        chk({nm, "_err"}, 32'(err), 0);
    endfunction

    // Host ready pattern: 0 always, 1 one-in-four, 2 random, 3 accept two then stall.
    initial begin
        rif.rd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       rif.rd_ready = 1'b1;
                1:       rif.rd_ready = ((cyc % 4) == 0);
                2:       rif.rd_ready = 1'($urandom % 2);
                default: rif.rd_ready = ((beats - beat_base) < 2);
            endcase
        end
    end

    // Scoreboard / compare process.
    logic          p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0, p_done = 1'b0;
    logic [DW-1:0] p_data = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            p_valid = 1'b0;
            p_done  = 1'b0;
        end else begin
            if (p_valid && !p_ready) begin
                chk("stall_valid", 32'(rif.rd_valid), 1);
                chk("stall_data", 32'(rif.rd_data), 32'(p_data));
                chk("stall_last", 32'(rif.rd_last), 32'(p_last));
            end
            if (rif.rd_valid) valid_cyc++;
            if (rif.rd_valid && rif.rd_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_beat: got data 0x%0h with no word expected", rif.rd_data);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    chk("rd_data", 32'(rif.rd_data), 32'(e));
                    chk("rd_last", 32'(rif.rd_last), 32'(exp_q.size() == 0));
                    beats++;
                    last_acc_cyc = cyc;
                end
            end
            if (done) begin
                chk("done_width", 32'(p_done), 0);
                done_cnt++;
                done_cyc = cyc;
            end
            if (rif.out_sram_re) re_cnt++;
            if (dut_run) run_cyc++;
            p_valid = rif.rd_valid;
            p_ready = rif.rd_ready;
            p_data  = rif.rd_data;
            p_last  = rif.rd_last;
            p_done  = done;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 host_start = 1'b1;
        @(posedge clk); #1 host_start = 1'b0;
    endtask

    // One complete run of n controller writes; rst_beat >= 0 resets while holding that word.
    task automatic do_run(int n, int rmode, bit coincide, bit start_mid, int rst_beat);
        int  exp_wc, bound, vbase, rebase, dbase;
        bit  got;
        exp_wc = (n > int'(DEPTH)) ? int'(DEPTH) : n;
        for (int a = 0; a < exp_wc; a++)
            exp_q.push_back((a + int'(DEPTH) < n) ? wdata[a + int'(DEPTH)] : wdata[a]);
        ready_mode = rmode;
        beat_base  = beats;
        vbase      = valid_cyc;
        rebase     = re_cnt;
        dbase      = done_cnt;

        pulse_start();
        chk("launch_dut_run", 32'(dut_run), 1);
        chk("start_clears_err", 32'(err), 0);
        chk("start_clears_wc", 32'(word_count), 0);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 dut_busy = 1'b1;
        @(posedge clk); #1;
        if (start_mid) begin
            host_start = 1'b1;
            @(posedge clk); #1 host_start = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            if (coincide && i == n - 1) dut_busy = 1'b0;
            snoop_we = 1'b1;
            mem[i % int'(DEPTH)] = wdata[i];
            @(posedge clk); #1 snoop_we = 1'b0;
            if (n < 64) repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        if (!coincide) begin
            dut_busy = 1'b0;
            if (n == 0) begin
                @(posedge clk); @(negedge clk);
                chk("done_after_busy_fall", 32'(done), 1);
            end else begin
                @(posedge clk); @(posedge clk); @(negedge clk);
                chk("latency_early", 32'(rif.rd_valid), 0);
                @(posedge clk); @(negedge clk);
                chk("latency_first_valid", 32'(rif.rd_valid), 1);
            end
        end
        got = (n == 0 && !coincide);
        bound = 10 * exp_wc + 100;
        for (int k = 0; k < bound && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else if (rst_beat >= 0 && rif.rd_valid && (beats - beat_base) == rst_beat) begin
                chk("hold_word_before_reset", 32'(rif.rd_data), 32'(wdata[rst_beat]));
                rst_n = 1'b0;
                #1 chk_zero("reset_in_hold");
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                ready_mode = 0;
                return;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: no done within %0d cycles (n=%0d)", bound, n);
            return;
        end
        @(posedge clk); #1;
        chk("word_count", 32'(word_count), 32'(exp_wc));
        chk("err_clear", 32'(err), 0);
        chk("beats", 32'(beats - beat_base), 32'(exp_wc));
        chk("leftover_words", 32'(exp_q.size()), 0);
        chk("done_pulses", 32'(done_cnt - dbase), 1);
        chk("sram_reads", 32'(re_cnt - rebase), 32'(exp_wc));
        chk("back_to_idle", 32'(host_busy), 0);
        if (n > 0) chk("done_after_last", 32'(done_cyc - last_acc_cyc), 1);
        else chk("no_valid", 32'(valid_cyc - vbase), 0);
        exp_q.delete();
    endtask

    initial begin
        int rbase, rebase, dbase, n;
        bit got;

        #1 chk_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) chk_zero("reset_held");
        @(posedge clk); #1 rst_n = 1'b1;

        // Five known words, host always ready.
        for (int i = 0; i < 5; i++) wdata[i] = DW'((i + 1) * 16'h0011);
        do_run(5, 0, 1'b0, 1'b0, -1);
        chk("t1_word_count_literal", 32'(word_count), 5);

        // Same words, host ready one cycle in four.
        do_run(5, 1, 1'b0, 1'b0, -1);

        // Controller never responds: launch timeout.
        rbase = run_cyc; rebase = re_cnt; dbase = done_cnt;
        pulse_start();
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("timeout_done_seen", 32'(got), 1);
        @(posedge clk); #1;
        chk("timeout_run_cycles", 32'(run_cyc - rbase), 255);
        chk("timeout_err", 32'(err), 1);
        chk("timeout_no_read", 32'(re_cnt - rebase), 0);
        chk("timeout_done_pulses", 32'(done_cnt - dbase), 1);
        chk("timeout_word_count", 32'(word_count), 0);

        // Run with no writes at all.
        do_run(0, 0, 1'b0, 1'b0, -1);

        // Start pulse during RUN plus a write coincident with busy falling.
        for (int i = 0; i < 4; i++) wdata[i] = DW'($urandom);
        do_run(4, 0, 1'b1, 1'b1, -1);
        chk("t6_word_count_literal", 32'(word_count), 4);

        // Reset while holding word 2 of 5, then a fresh 3-word run.
        for (int i = 0; i < 5; i++) wdata[i] = DW'($urandom);
        do_run(5, 3, 1'b0, 1'b0, 2);
        for (int i = 0; i < 3; i++) wdata[i] = DW'($urandom);
        do_run(3, 0, 1'b0, 1'b0, -1);
        chk("t5_word_count_literal", 32'(word_count), 3);

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) wdata[i] = DW'($urandom);
            do_run(n, $urandom_range(0, 2), 1'($urandom % 2), 1'($urandom % 2), -1);
        end

        // Saturation: more writes than the address space holds.
        for (int i = 0; i < 4100; i++) wdata[i] = DW'($urandom);
        do_run(4100, 0, 1'b0, 1'b0, -1);
        chk("sat_word_count_literal", 32'(word_count), 4096);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/result_readout.md
Name: result_readout

Overview:
Host-side counterpart to the convolution controller. It launches a run by handshaking `dut_run` against `dut_busy`, and counts the output-SRAM writes it snoops during the run. When the run finishes it reads those words back from the output SRAM and streams them to the host on a valid/ready port. It sits between the host/testbench wrapper and the output SRAM read port.

Parameters:
- ADDR_W, 12, output SRAM address width; matches the controller's 12-bit address paths.
- DATA_W, 16, output SRAM word width.
- LAUNCH_TIMEOUT, 255, maximum cycles in LAUNCH waiting for `dut_busy` before aborting.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- host_start  in  1  start request; sampled only in IDLE.
- host_busy  out  1  high in every state except IDLE.
- dut_run  out  1  run request to the convolution controller.
- dut_busy  in  1  registered busy from the controller.
- snoop_we  in  1  output-SRAM write enable driven by the controller.
- out_sram_re  out  1  output SRAM read enable.
- out_sram_addr  out  ADDR_W  output SRAM read address.
- out_sram_rdata  in  DATA_W  read data, valid exactly 1 cycle after `out_sram_re`.
- rd_valid  out  1  result word available to the host.
- rd_data  out  DATA_W  result word.
- rd_last  out  1  qualifies the final word of a run; meaningful only with `rd_valid`.
- rd_ready  in  1  host accepts the word.
- word_count  out  ADDR_W+1  number of writes snooped in the current run.
- done  out  1  one-cycle pulse at end of a run.
- err  out  1  sticky launch-timeout flag; cleared by the next accepted `host_start`.

Behaviour:
- Reset (asynchronous, active-low) forces state IDLE and all outputs, counters and the data holding register to 0. This applies mid-run as well; there is no drain and no partial read.
- The state register is 3 bits: IDLE, LAUNCH, RUN, READ, WAIT, HOLD, DONE.
- IDLE
  - `host_start`=1 clears `word_count`, `err` and the timeout counter, then goes to LAUNCH.
  - Otherwise stays in IDLE.
- LAUNCH
  - `dut_run`=1 for the whole state.
  - `dut_busy`=1 goes to RUN; `dut_run` drops on that cycle boundary.
  - When the timeout counter reaches LAUNCH_TIMEOUT: set `err`=1, go to DONE.
- RUN
  - `dut_run`=0.
  - Each cycle with `snoop_we`=1 increments `word_count`, saturating at 2^ADDR_W.
  - `dut_busy`=0: goes to DONE if `word_count`==0, else to READ with `out_sram_addr`=0.
  - A `snoop_we` on the same cycle that `dut_busy` falls is still counted.
- READ
  - `out_sram_re`=1 with the current address, for one cycle, then goes to WAIT.
- WAIT
  - Captures `out_sram_rdata` into the holding register, then goes to HOLD.
- HOLD
  - `rd_valid`=1 and `rd_data`=holding register.
  - `rd_last`=1 when `out_sram_addr` == `word_count`-1.
  - `rd_data` and `rd_last` stay stable while `rd_valid`=1 and `rd_ready`=0; there is no timeout on `rd_ready`.
  - On `rd_ready`=1: if last, go to DONE; else increment the address and go to READ.
- DONE
  - `done`=1 for exactly one cycle, then goes to IDLE. `word_count` holds its value until the next start.
- Throughput is 1 word per 3 cycles when `rd_ready` is held high.
- Latency from `dut_busy` falling to the first `rd_valid` is 3 cycles.
- `host_start` outside IDLE is ignored.
- If `word_count` is saturated, readout covers addresses 0..2^ADDR_W-1 with no wrap.
- All outputs are registered or decoded from the state register only; there are no combinational input-to-output paths.

Decomposition:
- Shared package `conv_pkg`:
  - state encoding localparams;
  - default ADDR_W/DATA_W shared with the controller and SRAM models.
- No sub-module is needed. The timeout counter, address counter and word counter are inline registers.

Test Plan:
1. Controller model writes 5 words (0x0011..0x0055) and then drops busy; `rd_ready` tied to 1.
   -> `word_count`=5; 5 `rd_valid` beats in address order 0..4; `rd_last` only on 0x0055; `done` pulse 1 cycle after the last accept.
2. Same run with `rd_ready` toggling 1-of-4 cycles.
   -> `rd_data` is stable across stalls; same 5 words; no duplicates or drops.
3. `dut_busy` never rises.
   -> `dut_run` high for 255 cycles; `err`=1; `done` pulses; no SRAM read issued.
4. Run completes with zero `snoop_we`.
   -> `done` 1 cycle after `dut_busy` falls; `rd_valid` never asserts; `err`=0.
5. Reset asserted while in HOLD on word 2 of 5.
   -> All outputs 0 immediately. A new `host_start` and a 3-word run then yield `word_count`=3 and words from address 0.
6. `host_start` pulsed during RUN; `snoop_we` coincident with busy falling.
   -> The start is ignored; the coincident write is counted (`word_count`=N+1).
